// File: rtl/legv8_alu_issue_pkg.sv
// legv8_alu_issue_pkg
//   Shared definitions for the LEGv8 ALU issue unit:
//     - FSM state encoding (state_t)
//     - B-operand source select (bsel_t)
//     - ALU function-select codes, FS = {mux[2:0], Binv, Ainv}
//     - 11-bit R-type and 10-bit I-type opcode constants
//     - decode_t record produced by the decoder, plus a constructor helper
package legv8_alu_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BSEL_RM    = 2'd0,
    BSEL_IMM   = 2'd1,
    BSEL_SHAMT = 2'd2
  } bsel_t;

  // ALU function select: mux selects AND/ORR/ADD/EOR/LSL/LSR,
  // Binv with carry-in 1 turns ADD into a two's-complement subtract.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // R-type opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_ADDS = 11'b101_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_SUBS = 11'b111_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ANDS = 11'b111_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_EOR  = 11'b110_0101_0000;
  localparam logic [10:0] OP_LSL  = 11'b110_1001_1011;
  localparam logic [10:0] OP_LSR  = 11'b110_1001_1010;

  // I-type opcodes, instr[31:22]
  localparam logic [9:0] OP_ADDI  = 10'b10_0100_0100;
  localparam logic [9:0] OP_ADDIS = 10'b10_1100_0100;
  localparam logic [9:0] OP_SUBI  = 10'b11_0100_0100;
  localparam logic [9:0] OP_SUBIS = 10'b11_1100_0100;
  localparam logic [9:0] OP_ANDI  = 10'b10_0100_1000;
  localparam logic [9:0] OP_ORRI  = 10'b10_1100_1000;
  localparam logic [9:0] OP_EORI  = 10'b11_0100_1000;

  typedef struct packed {
    logic [4:0] fs;
    logic       c0;
    bsel_t      bsel;
    logic       set_flags;
    logic       legal;
  } decode_t;

  // Builds the decode record for a supported instruction.
  function automatic decode_t mk_decode(input logic [4:0] fs, input logic c0,
                                        input bsel_t bsel, input logic set_flags);
    decode_t d;
    d.fs        = fs;
    d.c0        = c0;
    d.bsel      = bsel;
    d.set_flags = set_flags;
    d.legal     = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/legv8_alu_issue_decode.sv
// legv8_alu_issue_decode
//   Combinational opcode decoder for the LEGv8 ALU issue unit.
//   Ports:
//     opcode  in   11  instr[31:21]; I-type forms are matched on opcode[10:1]
//     dec     out  decode_t {fs, c0, bsel, set_flags, legal}
module legv8_alu_issue_decode
  import legv8_alu_issue_pkg::*;
(
  input  logic [10:0] opcode,
  output decode_t     dec
);

  // R-type encodings are tried first on all 11 bits; anything that misses
  // falls through to the 10-bit I-type table, and a miss there is illegal.
  always_comb begin
    dec      = '0;
    dec.bsel = BSEL_RM;
    case (opcode)
      OP_ADD:  dec = mk_decode(FS_ADD, 1'b0, BSEL_RM,    1'b0);
      OP_ADDS: dec = mk_decode(FS_ADD, 1'b0, BSEL_RM,    1'b1);
      OP_SUB:  dec = mk_decode(FS_SUB, 1'b1, BSEL_RM,    1'b0);
      OP_SUBS: dec = mk_decode(FS_SUB, 1'b1, BSEL_RM,    1'b1);
      OP_AND:  dec = mk_decode(FS_AND, 1'b0, BSEL_RM,    1'b0);
      OP_ANDS: dec = mk_decode(FS_AND, 1'b0, BSEL_RM,    1'b1);
      OP_ORR:  dec = mk_decode(FS_ORR, 1'b0, BSEL_RM,    1'b0);
      OP_EOR:  dec = mk_decode(FS_EOR, 1'b0, BSEL_RM,    1'b0);
      OP_LSL:  dec = mk_decode(FS_LSL, 1'b0, BSEL_SHAMT, 1'b0);
      OP_LSR:  dec = mk_decode(FS_LSR, 1'b0, BSEL_SHAMT, 1'b0);
      default: begin
        case (opcode[10:1])
          OP_ADDI:  dec = mk_decode(FS_ADD, 1'b0, BSEL_IMM, 1'b0);
          OP_ADDIS: dec = mk_decode(FS_ADD, 1'b0, BSEL_IMM, 1'b1);
          OP_SUBI:  dec = mk_decode(FS_SUB, 1'b1, BSEL_IMM, 1'b0);
          OP_SUBIS: dec = mk_decode(FS_SUB, 1'b1, BSEL_IMM, 1'b1);
          OP_ANDI:  dec = mk_decode(FS_AND, 1'b0, BSEL_IMM, 1'b0);
          OP_ORRI:  dec = mk_decode(FS_ORR, 1'b0, BSEL_IMM, 1'b0);
          OP_EORI:  dec = mk_decode(FS_EOR, 1'b0, BSEL_IMM, 1'b0);
          default:  dec = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/legv8_alu_issue.sv
// legv8_alu_issue
//   Issue side of the LEGv8 ALU: accepts a decoded-register-read instruction,
//   drives the external combinational ALU for one cycle, captures its result
//   and status, maintains the architectural NZCV register and hands the result
//   to writeback through a valid/ready handshake.
//   Ports:
//     clock, reset            rising-edge clock, async active-high reset
//     in_valid/in_ready       upstream handshake (ready only in IDLE)
//     instr, rd_a, rd_b       instruction word and Rn/Rm read data
//     alu_a/alu_b/alu_fs/alu_c0  registered ALU drive
//     alu_f, alu_status       ALU result and {V,C,N,Z}
//     res_valid/res_ready     downstream handshake
//     result, rd_idx, wr_en, illegal  writeback payload
//     flags                   architectural {V,C,N,Z}
//   DW must stay 64 to match the ALU.
module legv8_alu_issue
  import legv8_alu_issue_pkg::*;
#(
  parameter int DW    = 64,
  parameter int IMM_W = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rd_a,
  input  logic [DW-1:0] rd_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_fs,
  output logic          alu_c0,
  input  logic [DW-1:0] alu_f,
  input  logic [3:0]    alu_status,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] result,
  output logic [4:0]    rd_idx,
  output logic          wr_en,
  output logic          illegal,
  output logic [3:0]    flags
);

  state_t        state_q, state_d;
  decode_t       dec;
  logic [DW-1:0] b_next;
  logic          accept;
  logic          set_flags_q;
  logic          legal_q;

  // Register addresses for Rn/Rm are resolved upstream into rd_a/rd_b.
  logic unused_fields;
  assign unused_fields = ^{instr[20:16], instr[9:5]};

  legv8_alu_issue_decode u_decode (
    .opcode (instr[31:21]),
    .dec    (dec)
  );

  assign accept = (state_q == ST_IDLE) && in_valid;

  // B operand source: register, zero-extended 12-bit immediate, or shamt.
  always_comb begin
    b_next = rd_b;
    case (dec.bsel)
      BSEL_IMM:   b_next = DW'(instr[10 +: IMM_W]);
      BSEL_SHAMT: b_next = DW'(instr[15:10]);
      default:    b_next = rd_b;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The alu_* registers load at the accept edge so the ALU sees stable
  // operands for the whole EXEC cycle; an illegal instruction leaves them
  // at their previous values. Result and flags are captured at the end of EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_fs      <= '0;
      alu_c0      <= 1'b0;
      result      <= '0;
      rd_idx      <= '0;
      wr_en       <= 1'b0;
      illegal     <= 1'b0;
      flags       <= '0;
      set_flags_q <= 1'b0;
      legal_q     <= 1'b0;
    end else begin
      if (accept) begin
        rd_idx      <= instr[4:0];
        wr_en       <= dec.legal && (instr[4:0] != 5'd31);
        illegal     <= !dec.legal;
        set_flags_q <= dec.set_flags;
        legal_q     <= dec.legal;
        if (dec.legal) begin
          alu_a  <= rd_a;
          alu_b  <= b_next;
          alu_fs <= dec.fs;
          alu_c0 <= dec.c0;
        end
      end
      if (state_q == ST_EXEC) begin
        result <= legal_q ? alu_f : '0;
        if (legal_q && set_flags_q) flags <= alu_status;
      end
    end
  end

endmodule

// File: tb/tb_legv8_alu_issue.sv
// tb_legv8_alu_issue
//   Table-driven bench for legv8_alu_issue with a behavioural 64-bit ALU
//   connected to the alu_* ports, plus hand-written handshake and reset sequences.
module tb_legv8_alu_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] rd_a, rd_b;
  logic [63:0] alu_a, alu_b, alu_f;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic [3:0]  alu_status;
  logic        res_valid, res_ready;
  logic [63:0] result;
  logic [4:0]  rd_idx;
  logic        wr_en, illegal;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  legv8_alu_issue #(.DW(64), .IMM_W(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_c0     (alu_c0),
    .alu_f      (alu_f),
    .alu_status (alu_status),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .rd_idx     (rd_idx),
    .wr_en      (wr_en),
    .illegal    (illegal),
    .flags      (flags)
  );

  // Behavioural LEGv8 ALU: FS = {mux[2:0], Binv, Ainv}, status {V,C,N,Z}.
  logic [63:0] a_eff, b_eff, f_m;
  logic [64:0] sum;
  logic        v_m, c_m;
  always_comb begin
    a_eff = alu_fs[0] ? ~alu_a : alu_a;
    b_eff = alu_fs[1] ? ~alu_b : alu_b;
    sum   = {1'b0, a_eff} + {1'b0, b_eff} + {64'd0, alu_c0};
    f_m   = '0;
    v_m   = 1'b0;
    c_m   = 1'b0;
    case (alu_fs[4:2])
      3'd0: f_m = a_eff & b_eff;
      3'd1: f_m = a_eff | b_eff;
      3'd2: begin
        f_m = sum[63:0];
        c_m = sum[64];
        v_m = (a_eff[63] == b_eff[63]) && (sum[63] != a_eff[63]);
      end
      3'd3: f_m = a_eff ^ b_eff;
      3'd4: f_m = a_eff << alu_b[5:0];
      3'd5: f_m = a_eff >> alu_b[5:0];
      default: f_m = '0;
    endcase
    alu_f      = f_m;
    alu_status = {v_m, c_m, f_m[63], (f_m == 64'd0)};
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [4:0]  exp_fs;
    logic        exp_c0;
    logic [63:0] exp_result;
    logic        exp_wr_en;
    logic        exp_illegal;
    logic [3:0]  exp_flags;
    logic [4:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one instruction, checks the ALU drive during EXEC and the
  // payload in DONE, then releases it with res_ready.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n;
    @(negedge clock);
    checkOutput($sformatf("v%0d in_ready idle", idx), {63'd0, in_ready}, 64'd1);
    instr    = v.instr;
    rd_a     = v.a;
    rd_b     = v.b;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    instr    = 32'hFFFF_FFFF;
    rd_a     = '1;
    rd_b     = '1;
    checkOutput($sformatf("v%0d res_valid exec", idx), {63'd0, res_valid}, 64'd0);
    checkOutput($sformatf("v%0d alu_a", idx), alu_a, v.exp_a);
    checkOutput($sformatf("v%0d alu_b", idx), alu_b, v.exp_b);
    checkOutput($sformatf("v%0d alu_fs", idx), {59'd0, alu_fs}, {59'd0, v.exp_fs});
    checkOutput($sformatf("v%0d alu_c0", idx), {63'd0, alu_c0}, {63'd0, v.exp_c0});
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!res_valid && n < 5);
    checkOutput($sformatf("v%0d latency", idx), 64'(n), 64'd1);
    checkOutput($sformatf("v%0d result", idx), result, v.exp_result);
    checkOutput($sformatf("v%0d wr_en", idx), {63'd0, wr_en}, {63'd0, v.exp_wr_en});
    checkOutput($sformatf("v%0d illegal", idx), {63'd0, illegal}, {63'd0, v.exp_illegal});
    checkOutput($sformatf("v%0d flags", idx), {60'd0, flags}, {60'd0, v.exp_flags});
    checkOutput($sformatf("v%0d rd_idx", idx), {59'd0, rd_idx}, {59'd0, v.exp_rd});
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    checkOutput($sformatf("v%0d back idle", idx), {62'd0, res_valid, in_ready}, 64'd1);
  endtask

  initial begin
    // instr, a, b, exp_a, exp_b, fs, c0, result, wr_en, illegal, flags, rd
    vecs[0]  = '{32'h8B02_0023, 64'd5, 64'd7, 64'd5, 64'd7, 5'b01000, 1'b0,
                 64'd12, 1'b1, 1'b0, 4'b0000, 5'd3};                      // ADD X3,X1,X2
    vecs[1]  = '{32'hEB02_003F, 64'd3, 64'd3, 64'd3, 64'd3, 5'b01010, 1'b1,
                 64'd0, 1'b0, 1'b0, 4'b0101, 5'd31};                      // SUBS XZR,X1,X2
    vecs[2]  = '{32'hD360_1024, 64'd1, 64'hDEAD, 64'd1, 64'd4, 5'b10000, 1'b0,
                 64'd16, 1'b1, 1'b0, 4'b0101, 5'd4};                      // LSL X4,X1,#4
    vecs[3]  = '{32'h913F_FC25, 64'd1, 64'd99, 64'd1, 64'h0FFF, 5'b01000, 1'b0,
                 64'h1000, 1'b1, 1'b0, 4'b0101, 5'd5};                    // ADDI X5,X1,#0xFFF
    vecs[4]  = '{32'hFFE0_0006, 64'd9, 64'd9, 64'd1, 64'h0FFF, 5'b01000, 1'b0,
                 64'd0, 1'b0, 1'b1, 4'b0101, 5'd6};                       // opcode 0x7FF
    vecs[5]  = '{32'hEA02_0027, 64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000, 5'b00000, 1'b0,
                 64'h8000_0000_0000_0000, 1'b1, 1'b0, 4'b0010, 5'd7};     // ANDS X7,X1,X2
    vecs[6]  = '{32'hD203_C028, 64'hFF, 64'd0, 64'hFF, 64'hF0, 5'b01100, 1'b0,
                 64'h0F, 1'b1, 1'b0, 4'b0010, 5'd8};                      // EORI X8,X1,#0xF0
    vecs[7]  = '{32'hAA02_0029, 64'hF0, 64'h0F, 64'hF0, 64'h0F, 5'b00100, 1'b0,
                 64'hFF, 1'b1, 1'b0, 4'b0010, 5'd9};                      // ORR X9,X1,X2
    vecs[8]  = '{32'hD340_202A, 64'hFF00, 64'd0, 64'hFF00, 64'd8, 5'b10100, 1'b0,
                 64'hFF, 1'b1, 1'b0, 4'b0010, 5'd10};                     // LSR X10,X1,#8
    vecs[9]  = '{32'hAB02_002B, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
                 4'b1010, 5'd11};                                         // ADDS overflow
    vecs[10] = '{32'hF100_042C, 64'd0, 64'd0, 64'd0, 64'd1, 5'b01010, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'b0010, 5'd12};    // SUBIS X12,X1,#1
    vecs[11] = '{32'hD100_082D, 64'd10, 64'd0, 64'd10, 64'd2, 5'b01010, 1'b1,
                 64'd8, 1'b1, 1'b0, 4'b0010, 5'd13};                      // SUBI X13,X1,#2

    reset     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    instr     = '0;
    rd_a      = '0;
    rd_b      = '0;
    #1;
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset flags", {60'd0, flags}, 64'd0);
    checkOutput("reset wr_en/illegal/rd", {57'd0, wr_en, illegal, rd_idx}, 64'd0);
    checkOutput("reset alu", {alu_a[31:0], alu_b[25:0], alu_fs, alu_c0}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Hold res_ready low for three DONE cycles while a new request is offered.
    @(negedge clock);
    instr    = 32'h8B02_0023;
    rd_a     = 64'd2;
    rd_b     = 64'd2;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr = 32'hEB02_003F;
    rd_a  = 64'd100;
    rd_b  = 64'd1;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold%0d valid/ready", k), {62'd0, res_valid, in_ready}, 64'd2);
      checkOutput($sformatf("hold%0d result", k), result, 64'd4);
      checkOutput($sformatf("hold%0d flags", k), {60'd0, flags}, 64'd2);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    checkOutput("hold4 result", result, 64'd4);
    @(negedge clock);
    res_ready = 1'b0;
    checkOutput("hold release", {62'd0, res_valid, in_ready}, 64'd1);
    checkOutput("hold alu_a untouched", alu_a, 64'd2);

    // Reset while in EXEC aborts the in-flight SUBS.
    @(negedge clock);
    instr    = 32'hEB02_003F;
    rd_a     = 64'd3;
    rd_b     = 64'd3;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("rst exec valid/ready", {62'd0, res_valid, in_ready}, 64'd1);
    checkOutput("rst exec flags", {60'd0, flags}, 64'd0);
    checkOutput("rst exec result", result, 64'd0);
    @(negedge clock);
    checkOutput("rst held valid", {63'd0, res_valid}, 64'd0);
    reset = 1'b0;

    applyStimulus(vecs[0], 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
